// File: rtl/exec_unit.sv
// exec_unit: serialised execute/write-back sequencer in front of a 4x8
// register file with a one-cycle registered read port.
// Each accepted instruction walks IDLE -> READ -> EXEC -> WB -> IDLE, so it
// occupies the block for exactly four cycles.
// Optional build macro: EXEC_CMP_EN turns opcode 10 into CMP (flags only).
// Without it, opcode 10 is illegal like 11-15.
module exec_unit #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [7:0]        instr,
  input  logic [DATA_W-1:0] imm,
  output logic [ADDR_W-1:0] rf_address_a,
  output logic [ADDR_W-1:0] rf_address_b,
  output logic              rf_write_enable,
  output logic [DATA_W-1:0] rf_write_data,
  input  logic [DATA_W-1:0] rf_data_a,
  input  logic [DATA_W-1:0] rf_data_b,
  output logic [DATA_W-1:0] result,
  output logic              flag_z,
  output logic              flag_c,
  output logic              done,
  output logic              illegal
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_t;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_LDI = 4'd1;
  localparam logic [3:0] OP_MOV = 4'd2;
  localparam logic [3:0] OP_ADD = 4'd3;
  localparam logic [3:0] OP_SUB = 4'd4;
  localparam logic [3:0] OP_AND = 4'd5;
  localparam logic [3:0] OP_OR  = 4'd6;
  localparam logic [3:0] OP_XOR = 4'd7;
  localparam logic [3:0] OP_SHL = 4'd8;
  localparam logic [3:0] OP_SHR = 4'd9;
`ifdef EXEC_CMP_EN
  localparam logic [3:0] OP_CMP = 4'd10;
`endif

  state_t              state_r;
  logic [3:0]          op_r;
  logic [DATA_W-1:0]   imm_r;
  logic                ready_r;
  logic [ADDR_W-1:0]   addr_a_r;
  logic [ADDR_W-1:0]   addr_b_r;
  logic [DATA_W-1:0]   result_r;
  logic                flag_z_r;
  logic                flag_c_r;
  logic                we_r;
  logic                done_r;
  logic                illegal_r;

  logic [DATA_W:0]     sum_s;
  logic [DATA_W:0]     diff_s;
  logic [DATA_W-1:0]   alu_res_s;
  logic                alu_wr_s;
  logic                alu_ill_s;
  logic                alu_c_s;
  logic                alu_z_s;
  logic                alu_z_nowr_s;

  // ALU: next result/flags from the registered operands seen in EXEC.
  always_comb begin
    sum_s        = {1'b0, rf_data_a} + {1'b0, rf_data_b};
    diff_s       = {1'b0, rf_data_a} - {1'b0, rf_data_b};
    alu_res_s    = result_r;
    alu_wr_s     = 1'b0;
    alu_ill_s    = 1'b0;
    alu_c_s      = flag_c_r;
    alu_z_nowr_s = flag_z_r;
    case (op_r)
      OP_NOP: alu_wr_s = 1'b0;
      OP_LDI: begin alu_res_s = imm_r;                 alu_wr_s = 1'b1; end
      OP_MOV: begin alu_res_s = rf_data_b;             alu_wr_s = 1'b1; end
      OP_ADD: begin alu_res_s = sum_s[DATA_W-1:0];     alu_wr_s = 1'b1; alu_c_s = sum_s[DATA_W];  end
      OP_SUB: begin alu_res_s = diff_s[DATA_W-1:0];    alu_wr_s = 1'b1; alu_c_s = diff_s[DATA_W]; end
      OP_AND: begin alu_res_s = rf_data_a & rf_data_b; alu_wr_s = 1'b1; end
      OP_OR:  begin alu_res_s = rf_data_a | rf_data_b; alu_wr_s = 1'b1; end
      OP_XOR: begin alu_res_s = rf_data_a ^ rf_data_b; alu_wr_s = 1'b1; end
      OP_SHL: begin
        alu_res_s = {rf_data_a[DATA_W-2:0], 1'b0};
        alu_wr_s  = 1'b1;
        alu_c_s   = rf_data_a[DATA_W-1];
      end
      OP_SHR: begin
        alu_res_s = {1'b0, rf_data_a[DATA_W-1:1]};
        alu_wr_s  = 1'b1;
        alu_c_s   = rf_data_a[0];
      end
`ifdef EXEC_CMP_EN
      OP_CMP: begin
        alu_z_nowr_s = (diff_s[DATA_W-1:0] == {DATA_W{1'b0}});
        alu_c_s      = diff_s[DATA_W];
      end
`endif
      default: alu_ill_s = 1'b1;
    endcase
    // Writing opcodes derive Z from the written value; others keep or set it above.
    alu_z_s = alu_wr_s ? (alu_res_s == {DATA_W{1'b0}}) : alu_z_nowr_s;
  end

  // Sequencer: instruction latch, state walk and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      op_r      <= 4'd0;
      imm_r     <= {DATA_W{1'b0}};
      ready_r   <= 1'b1;
      addr_a_r  <= {ADDR_W{1'b0}};
      addr_b_r  <= {ADDR_W{1'b0}};
      result_r  <= {DATA_W{1'b0}};
      flag_z_r  <= 1'b0;
      flag_c_r  <= 1'b0;
      we_r      <= 1'b0;
      done_r    <= 1'b0;
      illegal_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          we_r      <= 1'b0;
          done_r    <= 1'b0;
          illegal_r <= 1'b0;
          if (instr_valid && ready_r) begin
            op_r     <= instr[7:4];
            addr_a_r <= instr[3:2];
            addr_b_r <= instr[1:0];
            imm_r    <= imm;
            ready_r  <= 1'b0;
            state_r  <= READ;
          end
        end
        READ: state_r <= EXEC;
        EXEC: begin
          result_r  <= alu_res_s;
          flag_z_r  <= alu_z_s;
          flag_c_r  <= alu_c_s;
          we_r      <= alu_wr_s;
          done_r    <= 1'b1;
          illegal_r <= alu_ill_s;
          state_r   <= WB;
        end
        WB: begin
          we_r      <= 1'b0;
          done_r    <= 1'b0;
          illegal_r <= 1'b0;
          ready_r   <= 1'b1;
          state_r   <= IDLE;
        end
        default: begin
          we_r      <= 1'b0;
          done_r    <= 1'b0;
          illegal_r <= 1'b0;
          ready_r   <= 1'b1;
          state_r   <= IDLE;
        end
      endcase
    end
  end

  // Handshake and write-back strobes are masked by rst so an instruction
  // caught in WB when reset arrives never reaches the regfile.
  assign instr_ready     = ready_r & ~rst;
  assign rf_write_enable = we_r & ~rst;
  assign done            = done_r & ~rst;
  assign illegal         = illegal_r & ~rst;

  assign rf_address_a  = addr_a_r;
  assign rf_address_b  = addr_b_r;
  assign rf_write_data = result_r;
  assign result        = result_r;
  assign flag_z        = flag_z_r;
  assign flag_c        = flag_c_r;

endmodule

// File: tb/tb_exec_unit.sv
// tb_exec_unit: directed self-checking bench for exec_unit, with a small
// 4x8 registered-read regfile model attached to the rf_* ports.
module tb_exec_unit;

`ifdef EXEC_CMP_EN
  localparam bit CMP_EN = 1'b1;
`else
  localparam bit CMP_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] instr;
  logic [7:0] imm;
  logic [1:0] rf_address_a;
  logic [1:0] rf_address_b;
  logic       rf_write_enable;
  logic [7:0] rf_write_data;
  logic [7:0] rf_data_a;
  logic [7:0] rf_data_b;
  logic [7:0] result;
  logic       flag_z;
  logic       flag_c;
  logic       done;
  logic       illegal;

  logic [7:0] rf_mem [4];

  int n_total = 0;
  int n_pass  = 0;

  exec_unit dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .imm(imm),
    .rf_address_a(rf_address_a), .rf_address_b(rf_address_b),
    .rf_write_enable(rf_write_enable), .rf_write_data(rf_write_data),
    .rf_data_a(rf_data_a), .rf_data_b(rf_data_b),
    .result(result), .flag_z(flag_z), .flag_c(flag_c),
    .done(done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Regfile model: single write port at address_a, registered reads, no reset.
  always @(posedge clk) begin
    if (rf_write_enable) rf_mem[rf_address_a] <= rf_write_data;
    rf_data_a <= rf_mem[rf_address_a];
    rf_data_b <= rf_mem[rf_address_b];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // Issue one instruction and check its four-cycle handshake/strobe timing.
  task automatic issue(input string nm, input logic [3:0] op, input logic [1:0] ra,
                       input logic [1:0] rb, input logic [7:0] iv,
                       input logic exp_we, input logic exp_ill);
    int waited = 0;
    @(negedge clk);
    while (!instr_ready && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    check({nm, ".accept"}, 32'(instr_ready), 32'd1);
    instr = {op, ra, rb}; imm = iv; instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0; instr = 8'hA5; imm = 8'h5A;
    @(negedge clk); // READ
    check({nm, ".read_ready"}, 32'(instr_ready), 32'd0);
    check({nm, ".addr_ab"}, 32'({rf_address_a, rf_address_b}), 32'({ra, rb}));
    @(negedge clk); // EXEC
    check({nm, ".exec_done"}, 32'({done, rf_write_enable}), 32'd0);
    @(negedge clk); // WB
    check({nm, ".wb_strobes"}, 32'({done, rf_write_enable, illegal, instr_ready}),
          32'({1'b1, exp_we, exp_ill, 1'b0}));
    @(negedge clk); // back in IDLE
    check({nm, ".idle"}, 32'({instr_ready, done, illegal}), 32'b100);
  endtask

  task automatic expect_state(input string nm, input logic [7:0] res, input logic z,
                              input logic c, input logic [1:0] r, input logic [7:0] rv);
    check({nm, ".result"}, 32'(result), 32'(res));
    check({nm, ".zc"}, 32'({flag_z, flag_c}), 32'({z, c}));
    check({nm, ".reg"}, 32'(rf_mem[r]), 32'(rv));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen_we;
    logic seen_done;
    int   last_acc;
    int   n_acc;
    logic [7:0] pend_imm;

    rst = 1'b1; instr_valid = 1'b0; instr = 8'h00; imm = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.ready", 32'(instr_ready), 32'd0);
    check("rst.result", 32'(result), 32'd0);
    check("rst.strobes", 32'({flag_z, flag_c, done, illegal, rf_write_enable}), 32'd0);
    check("rst.addr_wdata", 32'({rf_address_a, rf_address_b, rf_write_data}), 32'd0);
    rst = 1'b0;
    #1;
    check("rst.ready_after", 32'(instr_ready), 32'd1);

    issue("ldi_r1", 4'd1, 2'd1, 2'd0, 8'h3C, 1'b1, 1'b0);
    expect_state("ldi_r1", 8'h3C, 1'b0, 1'b0, 2'd1, 8'h3C);
    issue("ldi_r2", 4'd1, 2'd2, 2'd0, 8'hC4, 1'b1, 1'b0);
    expect_state("ldi_r2", 8'hC4, 1'b0, 1'b0, 2'd2, 8'hC4);
    issue("add", 4'd3, 2'd1, 2'd2, 8'h00, 1'b1, 1'b0);
    expect_state("add", 8'h00, 1'b1, 1'b1, 2'd1, 8'h00);
    issue("sub", 4'd4, 2'd1, 2'd2, 8'h00, 1'b1, 1'b0);
    expect_state("sub", 8'h3C, 1'b0, 1'b1, 2'd1, 8'h3C);
    issue("ldi_r3", 4'd1, 2'd3, 2'd0, 8'h81, 1'b1, 1'b0);
    expect_state("ldi_r3", 8'h81, 1'b0, 1'b1, 2'd3, 8'h81);
    issue("shr", 4'd9, 2'd3, 2'd0, 8'h00, 1'b1, 1'b0);
    expect_state("shr", 8'h40, 1'b0, 1'b1, 2'd3, 8'h40);
    issue("ldi_r0", 4'd1, 2'd0, 2'd0, 8'hFF, 1'b1, 1'b0);
    expect_state("ldi_r0", 8'hFF, 1'b0, 1'b1, 2'd0, 8'hFF);
    issue("and", 4'd5, 2'd3, 2'd0, 8'h00, 1'b1, 1'b0);
    expect_state("and", 8'h40, 1'b0, 1'b1, 2'd3, 8'h40);
    issue("op_f", 4'hF, 2'd1, 2'd2, 8'h00, 1'b0, 1'b1);
    expect_state("op_f", 8'h40, 1'b0, 1'b1, 2'd1, 8'h3C);
    // Opcode 10: CMP r1,r1 when enabled (0x3C-0x3C -> Z=1, C=0), else illegal.
    issue("op_a", 4'hA, 2'd1, 2'd1, 8'h00, 1'b0, !CMP_EN);
    expect_state("op_a", 8'h40, CMP_EN, !CMP_EN, 2'd1, 8'h3C);
    issue("xor", 4'd7, 2'd1, 2'd1, 8'h00, 1'b1, 1'b0);
    expect_state("xor", 8'h00, 1'b1, !CMP_EN, 2'd1, 8'h00);
    issue("shl", 4'd8, 2'd2, 2'd0, 8'h00, 1'b1, 1'b0);
    expect_state("shl", 8'h88, 1'b0, 1'b1, 2'd2, 8'h88);
    issue("mov", 4'd2, 2'd0, 2'd2, 8'h00, 1'b1, 1'b0);
    expect_state("mov", 8'h88, 1'b0, 1'b1, 2'd0, 8'h88);
    issue("nop", 4'd0, 2'd3, 2'd1, 8'h00, 1'b0, 1'b0);
    expect_state("nop", 8'h88, 1'b0, 1'b1, 2'd3, 8'h40);
    issue("or", 4'd6, 2'd1, 2'd3, 8'h00, 1'b1, 1'b0);
    expect_state("or", 8'h40, 1'b0, 1'b1, 2'd1, 8'h40);

    // Reset arriving during EXEC of ADD r0,r1 must abort it cleanly.
    seen_we = 1'b0; seen_done = 1'b0;
    @(negedge clk);
    instr = {4'd3, 2'd0, 2'd1}; instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(negedge clk); // READ
    seen_we |= rf_write_enable; seen_done |= done;
    @(negedge clk); // EXEC
    seen_we |= rf_write_enable; seen_done |= done;
    rst = 1'b1;
    #1;
    seen_we |= rf_write_enable; seen_done |= done;
    @(negedge clk);
    seen_we |= rf_write_enable; seen_done |= done;
    check("abort.ready_in_rst", 32'(instr_ready), 32'd0);
    check("abort.result", 32'(result), 32'd0);
    check("abort.zc", 32'({flag_z, flag_c}), 32'd0);
    rst = 1'b0;
    #1;
    check("abort.ready_after", 32'(instr_ready), 32'd1);
    repeat (4) begin
      @(negedge clk);
      seen_we |= rf_write_enable; seen_done |= done;
    end
    check("abort.no_we_done", 32'({seen_we, seen_done}), 32'd0);
    check("abort.r0_kept", 32'(rf_mem[0]), 32'h88);

    // Valid held high with instr changing every cycle: only IDLE accepts count.
    n_acc = 0; last_acc = 0; pend_imm = 8'h00;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      instr = {4'd1, 2'd2, 2'd0}; imm = 8'h50 + 8'(c); instr_valid = 1'b1;
      if (done) begin
        check("stream.wb", 32'({rf_write_enable, rf_write_data}), 32'({1'b1, pend_imm}));
      end
      if (instr_ready) begin
        if (n_acc > 0) check("stream.gap", 32'(c - last_acc), 32'd4);
        last_acc = c;
        pend_imm = imm;
        n_acc++;
      end
    end
    @(negedge clk);
    instr_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("stream.accepts", 32'(n_acc), 32'd5);
    check("stream.r2_final", 32'(rf_mem[2]), 32'h60);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
